seq_controller: RTL

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/seq_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seq_controller.sv
// Purpose : 8-phase instruction sequencer for a small accumulator CPU; decodes memory/PC/IR/AC strobes.
// Latency : outputs are combinational decodes of the registered phase; one phase per clock, 8 clocks per instruction.
// Backpres: none; the sequence free-runs until an HLT freezes it at OP_ADDR, and only rst releases it.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous active-high reset (state -> INST_ADDR, halted cleared)
//   opcode      in   3  IR opcode: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//   zero        in   1  accumulator-is-zero flag
//   data_signal out  1  address mux select: 1 = PC, 0 = IR operand address
//   rd          out  1  memory read enable
//   wr          out  1  memory write strobe
//   ld_ir       out  1  instruction register load
//   ld_ac       out  1  accumulator load
//   inc_pc      out  1  program counter increment
//   ld_pc       out  1  program counter load (jump)
//   data_e      out  1  accumulator drives the data bus
//   halt        out  1  processor halted (sticky until rst)
//   phase       out  3  current state code, for debug
module seq_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       data_signal,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_t state;
  state_t state_nxt;
  logic   halted;
  logic   halted_nxt;

  // Opcode classes used by the decode.
  logic alu_op;
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  // State register; reset wins over both advance and halt-set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
    end
  end

  // Next state: strict +1 sequence. The only opcode-dependent branch is HLT
  // in OP_ADDR, which parks the sequencer in OP_ADDR and sets the sticky flag.
  always_comb begin
    state_nxt  = state;
    halted_nxt = halted;
    if (!halted) begin
      case (state)
        INST_ADDR:  state_nxt = INST_FETCH;
        INST_FETCH: state_nxt = INST_LOAD;
        INST_LOAD:  state_nxt = IDLE;
        IDLE:       state_nxt = OP_ADDR;
        OP_ADDR: begin
          if (is_hlt) begin
            state_nxt  = OP_ADDR;
            halted_nxt = 1'b1;
          end else begin
            state_nxt  = OP_FETCH;
          end
        end
        OP_FETCH:   state_nxt = ALU_OP;
        ALU_OP:     state_nxt = STORE;
        STORE:      state_nxt = INST_ADDR;
        default:    state_nxt = INST_ADDR;
      endcase
    end
  end

  // Output decode from registered state, opcode, zero and halted only.
  always_comb begin
    data_signal = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    ld_ir       = 1'b0;
    ld_ac       = 1'b0;
    inc_pc      = 1'b0;
    ld_pc       = 1'b0;
    data_e      = 1'b0;
    halt        = 1'b0;
    phase       = state;

    if (halted) begin
      // Frozen: only halt is visible; mux points at the operand address.
      halt = 1'b1;
    end else begin
      case (state)
        INST_ADDR: begin
          data_signal = 1'b1;
        end
        INST_FETCH: begin
          data_signal = 1'b1;
          rd          = 1'b1;
        end
        INST_LOAD: begin
          data_signal = 1'b1;
          rd          = 1'b1;
          ld_ir       = 1'b1;
        end
        IDLE: begin
          data_signal = 1'b1;
          rd          = 1'b1;
          ld_ir       = 1'b1;
        end
        OP_ADDR: begin
          // HLT announces itself here and withholds the PC increment.
          halt   = is_hlt;
          inc_pc = !is_hlt;
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          data_e = is_sto;
          wr     = is_sto;
        end
        default: begin
          data_signal = 1'b0;
        end
      endcase
    end
  end

endmodule
